parity_stream_chk: RTL and testbench
====================================

PARITY_STREAM_CHK -- requirements
Module: parity_stream_chk

Interface
REQ-001 Parameter DATA_W, default 32, total data width in bits; SHALL be a multiple of LANES.
REQ-002 Parameter LANES, default 4, number of independent parity lanes; lane width LW = DATA_W/LANES.
REQ-003 Parameter CNT_W, default 16, width of the error-beat counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  data word; lane i = in_data[(i+1)*LW-1 : i*LW].
REQ-009 in_parity  input  LANES  received parity bit per lane.
REQ-010 mode  input  1  1 = odd parity, 0 = even parity; sampled with the beat.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 out_err  output  LANES  per-lane parity error flags of the held beat.
REQ-014 err_cnt  output  CNT_W  saturating count of accepted beats with any lane error.
REQ-015 sticky_err  output  1  set once any error beat has been accepted.
REQ-016 clr_cnt  input  1  synchronous clear of err_cnt and sticky_err.

Function
REQ-017 Lane error: even mode, err[i] = XOR(lane i) ^ in_parity[i]; odd mode, err[i] = ~(XOR(lane i) ^ in_parity[i]).
REQ-018 in_ready = ~out_valid | out_ready (combinational); beat accepted when in_valid & in_ready.
REQ-019 On acceptance, out_err registers the computed flags and out_valid = 1 on the next cycle; latency exactly 1 cycle.
REQ-020 Held out_valid/out_err stay stable until out_valid & out_ready.
REQ-021 out_valid & out_ready with no new beat accepted: out_valid = 0 next cycle; with a new beat accepted in the same cycle: out_valid stays 1 with the new flags (full throughput).
REQ-022 err_cnt increments by 1 per accepted beat with |err != 0; holds at 2^CNT_W-1 (no wrap).
REQ-023 sticky_err sets on the same edge err_cnt increments; cleared only by clr_cnt or rst.
REQ-024 clr_cnt and an error beat accepted in the same cycle: err_cnt = 1, sticky_err = 1; clr_cnt without an error beat: both 0.
REQ-025 mode changes affect only beats accepted in or after the cycle of change; held results are not recomputed.

Reset
REQ-026 rst = 1: out_valid = 0, out_err = 0, err_cnt = 0, sticky_err = 0 on the next edge; in_ready = 1 the cycle after.
REQ-027 Reset mid-stream discards the held beat; a beat presented during rst is not accepted and not counted.

Structure
REQ-028 Package parity_pkg holds MODE_ODD = 1'b1, MODE_EVEN = 1'b0 and the lane-error function.
REQ-029 Sub-module parity_lane (combinational, LW-bit lane plus parity bit plus mode -> err) is instantiated LANES times via generate.
REQ-030 Output register, handshake logic and counter live in parity_stream_chk.

Verification (defaults unless stated)
REQ-031 mode=1, in_data=32'hFF005A1F, in_parity=4'b1110, out_ready=1 -> next cycle out_valid=1, out_err=4'b0000, err_cnt=0.
REQ-032 mode=0, same data/parity -> out_err=4'b1111, err_cnt=1, sticky_err=1.
REQ-033 out_ready=0, two back-to-back beats -> first held stable, in_ready=0, second not accepted until out_ready=1; no beat lost or duplicated.
REQ-034 CNT_W=4, 20 consecutive error beats -> err_cnt saturates at 15, sticky_err=1; clr_cnt with no error beat -> 0, 0.
REQ-035 clr_cnt coincident with an error beat -> err_cnt=1, sticky_err=1.
REQ-036 rst asserted while out_valid=1 and out_ready=0 -> out_valid=0, err_cnt=0 next cycle; the beat presented during rst is not reported.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared constants and the per-lane parity error rule for the parity stream checker.
package parity_pkg;

  localparam logic MODE_ODD  = 1'b1;
  localparam logic MODE_EVEN = 1'b0;

  // red_xor is the XOR of the lane's data bits. In odd mode the result is inverted.
  function automatic logic lane_err(input logic red_xor, input logic parity, input logic mode);
    return (red_xor ^ parity) ^ (mode == MODE_ODD);
  endfunction

endpackage

// File: rtl/parity_stream_chk_if.sv
// Beat-level bus for parity_stream_chk: input stream, result stream, counter/status.
// Handshake: a beat moves on a rising edge where valid & ready are both 1; a source
// holds valid and payload stable until that edge, and ready may depend on the sink's output valid.
interface parity_stream_chk_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LANES-1:0]  in_parity;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [LANES-1:0]  out_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              sticky_err;
  logic              clr_cnt;

  modport master (
    output in_valid, in_data, in_parity, mode, out_ready, clr_cnt,
    input  in_ready, out_valid, out_err, err_cnt, sticky_err
  );

  modport slave (
    input  in_valid, in_data, in_parity, mode, out_ready, clr_cnt,
    output in_ready, out_valid, out_err, err_cnt, sticky_err
  );
endinterface

// File: rtl/parity_lane.sv
// Combinational parity check of one LW-bit lane against its received parity bit.
module parity_lane
  import parity_pkg::*;
#(
  parameter int LW = 8
) (
  input  logic [LW-1:0] lane,
  input  logic          parity,
  input  logic          mode,
  output logic          err
);

  assign err = lane_err(^lane, parity, mode);

endmodule

// File: rtl/parity_stream_chk.sv
// Per-lane parity checker with a one-deep registered result stage and a saturating error-beat counter.
module parity_stream_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  parity_stream_chk_if.slave  bus
);

  // DATA_W must be a multiple of LANES; the lane slices assume an exact split.
  localparam int               LW      = DATA_W / LANES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES-1:0] lane_err_w;
  logic             accept;
  logic             err_beat;
  logic             out_valid_q;
  logic [LANES-1:0] out_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             sticky_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    parity_lane #(.LW(LW)) u_lane (
      .lane   (bus.in_data[i*LW +: LW]),
      .parity (bus.in_parity[i]),
      .mode   (bus.mode),
      .err    (lane_err_w[i])
    );
  end

  // The stage can take a new beat when empty or when its held result leaves this cycle.
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign err_beat     = accept & (|lane_err_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_err_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_err_q   <= lane_err_w;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // A clear coinciding with an error beat restarts the count at that beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else if (bus.clr_cnt) begin
      err_cnt_q <= err_beat ? CNT_W'(1) : '0;
      sticky_q  <= err_beat;
    end else if (err_beat) begin
      if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
      sticky_q <= 1'b1;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_err    = out_err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.sticky_err = sticky_q;

endmodule

// File: tb/tb_parity_stream_chk.sv
// Self-checking bench for parity_stream_chk: directed vector table, hand sequences, random traffic vs. a reference model.
module tb_parity_stream_chk;
  import parity_pkg::*;

  localparam int DATA_W  = 32;
  localparam int LANES   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_stream_chk_if #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) bif ();

  parity_stream_chk #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [LANES-1:0] exp_q[$];
  logic             m_valid  = 1'b0;
  logic [LANES-1:0] m_err    = '0;
  int               m_cnt    = 0;
  logic             m_sticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane i is in error when its data ones plus parity bit give the wrong total parity.
  function automatic logic [LANES-1:0] ref_err(input logic [DATA_W-1:0] d,
                                               input logic [LANES-1:0] p, input logic md);
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      int ones = $countones(d[i*8 +: 8]) + int'(p[i]);
      r[i] = (ones % 2) != ((md == MODE_ODD) ? 1 : 0);
    end
    return r;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Called just after a falling edge; applies inputs, checks ready/delivery, then post-edge state.
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic [LANES-1:0] p, input logic md, input logic ordy, input logic clr);
    logic             exp_ready;
    logic             acc;
    logic [LANES-1:0] e;
    logic [LANES-1:0] got;
    rst = r; bif.in_valid = v; bif.in_data = d; bif.in_parity = p;
    bif.mode = md; bif.out_ready = ordy; bif.clr_cnt = clr;
    #1;
    exp_ready = !m_valid || ordy;
    e   = ref_err(d, p, md);
    acc = !r && v && exp_ready;
    if (!r) begin
      chk("in_ready", 32'(bif.in_ready), 32'(exp_ready));
      if (m_valid && ordy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_delivery", 32'(bif.out_valid), 32'(0));
        end else begin
          got = exp_q.pop_front();
          chk("delivered_err", 32'(bif.out_err), 32'(got));
        end
      end
    end
    if (r) begin
      exp_q.delete();
      m_valid = 1'b0; m_err = '0; m_cnt = 0; m_sticky = 1'b0;
    end else begin
      if (acc) begin
        exp_q.push_back(e);
        m_valid = 1'b1; m_err = e;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (clr) begin
        m_cnt = (acc && e != 0) ? 1 : 0;
        m_sticky = acc && e != 0;
      end else if (acc && e != 0) begin
        m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        m_sticky = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("out_valid", 32'(bif.out_valid), 32'(m_valid));
    if (m_valid || r) chk("out_err", 32'(bif.out_err), 32'(m_err));
    chk("err_cnt", 32'(bif.err_cnt), 32'(m_cnt));
    chk("sticky_err", 32'(bif.sticky_err), 32'(m_sticky));
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              r, v;
    logic [DATA_W-1:0] d;
    logic [LANES-1:0]  p;
    logic              md, ordy, clr;
    logic              exp_valid;
    logic [LANES-1:0]  exp_err;
    logic [CNT_W-1:0]  exp_cnt;
    logic              exp_sticky;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.in_data = '0; bif.in_parity = '0;
    bif.mode = MODE_EVEN; bif.out_ready = 1'b0; bif.clr_cnt = 1'b0;

    //          r  v  data          par      mode       ordy clr  vld err      cnt sticky
    vecs[0] = '{1, 0, 32'h0,        4'b0000, MODE_EVEN, 1, 0,   0, 4'b0000, 0, 0};
    vecs[1] = '{0, 1, 32'hFF005A1F, 4'b1110, MODE_ODD,  1, 0,   1, 4'b0000, 0, 0};
    vecs[2] = '{0, 1, 32'hFF005A1F, 4'b1110, MODE_EVEN, 1, 0,   1, 4'b1111, 1, 1};
    vecs[3] = '{0, 0, 32'h0,        4'b0000, MODE_EVEN, 1, 0,   0, 4'b0000, 1, 1};
    vecs[4] = '{0, 1, 32'h0,        4'b0000, MODE_EVEN, 1, 0,   1, 4'b0000, 1, 1};
    vecs[5] = '{0, 1, 32'h0,        4'b1111, MODE_ODD,  1, 0,   1, 4'b0000, 1, 1};
    vecs[6] = '{0, 1, 32'h0,        4'b0101, MODE_ODD,  1, 0,   1, 4'b1010, 2, 1};
    vecs[7] = '{0, 0, 32'h0,        4'b0000, MODE_EVEN, 1, 1,   0, 4'b0000, 0, 0};
    vecs[8] = '{0, 1, 32'h1,        4'b0000, MODE_EVEN, 1, 1,   1, 4'b0001, 1, 1};
    vecs[9] = '{0, 0, 32'h0,        4'b0000, MODE_EVEN, 1, 0,   0, 4'b0000, 1, 1};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].md, vecs[i].ordy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(bif.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid || vecs[i].r)
        chk($sformatf("vec%0d_err", i), 32'(bif.out_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cnt", i), 32'(bif.err_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_sticky", i), 32'(bif.sticky_err), 32'(vecs[i].exp_sticky));
    end

    // Backpressure: first beat held, second waits, both delivered once in order.
    step(0, 1, 32'h0000_0003, 4'b0011, MODE_EVEN, 0, 0);  // A: lanes 0,1 in error
    step(0, 1, 32'h0000_0100, 4'b0000, MODE_EVEN, 0, 0);  // B blocked
    chk("bp_in_ready_low", 32'(bif.in_ready), 32'(0));
    chk("bp_held_err", 32'(bif.out_err), 32'(4'b0011));
    step(0, 1, 32'h0000_0100, 4'b0000, MODE_ODD, 0, 0);   // mode change while blocked: held A unaffected
    chk("bp_held_err2", 32'(bif.out_err), 32'(4'b0011));
    step(0, 1, 32'h0000_0100, 4'b0000, MODE_EVEN, 1, 0);  // A leaves, B enters
    chk("bp_b_err", 32'(bif.out_err), 32'(4'b0010));
    chk("bp_b_valid", 32'(bif.out_valid), 32'(1));
    step(0, 0, 32'h0, 4'b0000, MODE_EVEN, 1, 0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'(0));

    // Saturation of the 4-bit counter, then clear without an error beat.
    step(0, 0, 32'h0, 4'b0000, MODE_EVEN, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 32'h1, 4'b0000, MODE_EVEN, 1, 0);
    chk("sat_cnt", 32'(bif.err_cnt), 32'(15));
    chk("sat_sticky", 32'(bif.sticky_err), 32'(1));
    step(0, 1, 32'h0, 4'b0000, MODE_EVEN, 1, 1);
    chk("clr_cnt_zero", 32'(bif.err_cnt), 32'(0));
    chk("clr_sticky_zero", 32'(bif.sticky_err), 32'(0));

    // Reset while a result is held under backpressure; the beat during reset is dropped.
    step(0, 1, 32'h1, 4'b0000, MODE_EVEN, 0, 0);
    step(1, 1, 32'h1, 4'b0000, MODE_EVEN, 0, 0);
    chk("rst_valid", 32'(bif.out_valid), 32'(0));
    chk("rst_cnt", 32'(bif.err_cnt), 32'(0));
    chk("rst_ready", 32'(bif.in_ready), 32'(1));
    step(0, 0, 32'h0, 4'b0000, MODE_EVEN, 1, 0);
    chk("rst_no_report", 32'(bif.out_valid), 32'(0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom(),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
    end
    step(0, 0, 32'h0, 4'b0000, MODE_EVEN, 1, 0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
